dest_drain_arbiter: RTL and testbench

Downstream consumer of the full_logic transmission stage. It drains the two destination FIFOs (D0, D1) round-robin through their pop/empty/data interfaces and merges them into a single 6-bit stream tagged with its source. A 4-entry output buffer absorbs sink backpressure. Popping is gated by full_logic's `active_out`/`error_out` status.

---
 rtl/dest_drain_arbiter_if.sv | 36 +++
 rtl/dest_drain_arbiter.sv | 151 +++++++++++++++
 tb/tb_dest_drain_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_drain_arbiter_if.sv
// Handshake and status bundle between dest_drain_arbiter, the two destination
// FIFOs, full_logic status and the downstream sink.
interface dest_drain_arbiter_if #(
    parameter int data_width = 6
);
    logic                  active_in;
    logic                  error_in;
    logic                  empty_fifo_D0;
    logic                  empty_fifo_D1;
    logic [data_width-1:0] data_out_D0;
    logic [data_width-1:0] data_out_D1;
    logic                  ready_out;
    logic                  D0_pop;
    logic                  D1_pop;
    logic [data_width-1:0] data_out;
    logic                  src_out;
    logic                  valid_out;
    logic [1:0]            state_out;
    logic [7:0]            count_D0;
    logic [7:0]            count_D1;

    // master: FIFOs, full_logic and sink side; slave: the arbiter
    modport master (
        output active_in, error_in, empty_fifo_D0, empty_fifo_D1,
               data_out_D0, data_out_D1, ready_out,
        input  D0_pop, D1_pop, data_out, src_out, valid_out, state_out,
               count_D0, count_D1
    );

    modport slave (
        input  active_in, error_in, empty_fifo_D0, empty_fifo_D1,
               data_out_D0, data_out_D1, ready_out,
        output D0_pop, D1_pop, data_out, src_out, valid_out, state_out,
               count_D0, count_D1
    );
endinterface

// File: rtl/dest_drain_arbiter.sv
// Round-robin drain of destination FIFOs D0/D1 into one source-tagged stream
// with an OUT_DEPTH-entry output buffer. Define DEST_PKT_COUNT_EN for counters.
module dest_drain_arbiter #(
    parameter int OUT_DEPTH  = 4,
    parameter int data_width = 6
) (
    input  logic                clk,
    input  logic                reset,
    dest_drain_arbiter_if.slave bus
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_pop0;
    logic                  r_pop1;
    logic                  r_cap0;
    logic                  r_cap1;
    logic                  r_prio_d1;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_occ;
    logic [data_width-1:0] r_mem [OUT_DEPTH];
    logic                  r_src_mem [OUT_DEPTH];

    logic                  w_pop0;
    logic                  w_pop1;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_room;
    logic                  w_valid;
    logic                  w_capture;
    logic                  w_consume;
    logic                  w_quiet;
    logic                  w_head_src;
    logic [data_width-1:0] w_head_data;
    logic [data_width-1:0] w_cap_data;
    logic [CW:0]           w_reserved;

    assign w_valid     = (r_occ != '0);
    assign w_capture   = r_cap0 | r_cap1;
    assign w_consume   = w_valid & bus.ready_out;
    assign w_head_data = r_mem[r_rd_ptr];
    assign w_head_src  = r_src_mem[r_rd_ptr];
    assign w_cap_data  = r_cap1 ? bus.data_out_D1 : bus.data_out_D0;
    assign w_quiet     = ~w_valid & ~w_capture & ~r_pop0 & ~r_pop1;

    // Slots already promised: stored words plus pops whose data has not landed yet
    assign w_reserved = {1'b0, r_occ} + (CW+1)'(r_pop0 | r_pop1) + (CW+1)'(r_cap0 | r_cap1);
    assign w_room     = (w_reserved < (CW+1)'(OUT_DEPTH));
    assign w_elig0    = ~bus.empty_fifo_D0 & ~r_pop0 & w_room;
    assign w_elig1    = ~bus.empty_fifo_D1 & ~r_pop1 & w_room;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_pop0       = 1'b0;
        w_pop1       = 1'b0;
        case (r_state)
            ST_IDLE:  if (bus.active_in) w_next_state = ST_RUN;
            ST_RUN:   if (!bus.active_in) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_quiet) w_next_state = ST_IDLE;
            default:  w_next_state = ST_ERROR;
        endcase
        if (bus.error_in) w_next_state = ST_ERROR;

        // Gating on the next state keeps error_in/active_in effective at the same edge
        if (w_next_state == ST_RUN) begin
            if (r_prio_d1) begin
                if (w_elig1)      w_pop1 = 1'b1;
                else if (w_elig0) w_pop0 = 1'b1;
            end else begin
                if (w_elig0)      w_pop0 = 1'b1;
                else if (w_elig1) w_pop1 = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pop0    <= 1'b0;
            r_pop1    <= 1'b0;
            r_cap0    <= 1'b0;
            r_cap1    <= 1'b0;
            r_prio_d1 <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
        end else begin
            r_state <= w_next_state;
            r_pop0  <= w_pop0;
            r_pop1  <= w_pop1;
            r_cap0  <= r_pop0;
            r_cap1  <= r_pop1;
            if (w_pop0 | w_pop1) r_prio_d1 <= w_pop0;
            if (w_capture) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_consume) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_capture, w_consume})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // NOTE: buffer storage has no reset; occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr]     <= w_cap_data;
            r_src_mem[r_wr_ptr] <= r_cap1;
        end
    end

    assign bus.D0_pop    = r_pop0;
    assign bus.D1_pop    = r_pop1;
    assign bus.valid_out = w_valid;
    assign bus.data_out  = w_valid ? w_head_data : '0;
    assign bus.src_out   = w_valid & w_head_src;
    assign bus.state_out = r_state;

`ifdef DEST_PKT_COUNT_EN
    logic [7:0] r_cnt0;
    logic [7:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_consume) begin
            if (w_head_src) r_cnt1 <= r_cnt1 + 8'd1;
            else            r_cnt0 <= r_cnt0 + 8'd1;
        end
    end

    assign bus.count_D0 = r_cnt0;
    assign bus.count_D1 = r_cnt1;
`else
    assign bus.count_D0 = '0;
    assign bus.count_D1 = '0;
`endif
endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Self-checking bench for dest_drain_arbiter: queue-based FIFO and per-source
// ordering model, directed scenarios, then randomized traffic.
module tb_dest_drain_arbiter;
    localparam int DW    = 6;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dest_drain_arbiter_if #(.data_width(DW)) bus ();

    dest_drain_arbiter #(.OUT_DEPTH(DEPTH), .data_width(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] e0[$];
    logic [DW-1:0] e1[$];
    logic          pend0 = 1'b0;
    logic          pend1 = 1'b0;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_src;
    int            pops_total = 0;
    int            cons_total = 0;
    int            exp_cnt0 = 0;
    int            exp_cnt1 = 0;

    int t2_p0[7] = '{1, 0, 1, 0, 0, 0, 0};
    int t2_p1[7] = '{0, 1, 0, 1, 0, 0, 0};
    int t2_v[7]  = '{0, 0, 1, 1, 1, 1, 0};
    int t2_d[7]  = '{0, 0, 'h08, 'h16, 'h15, 'h14, 0};
    int t2_s[7]  = '{0, 0, 0, 1, 0, 1, 0};
    int t3_p0[7] = '{1, 0, 1, 0, 1, 0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [DW-1:0] v);
        q0.push_back(v);
        e0.push_back(v);
    endtask

    task automatic push1(input logic [DW-1:0] v);
        q1.push_back(v);
        e1.push_back(v);
    endtask

    // One clock: consume bookkeeping before the edge, FIFO model after it,
    // property checks on the following falling edge.
    task automatic cycle();
        logic [DW-1:0] w_exp;
        bus.empty_fifo_D0 = (q0.size() == 0);
        bus.empty_fifo_D1 = (q1.size() == 0);
        hold      = reset && bus.valid_out && !bus.ready_out;
        hold_data = bus.data_out;
        hold_src  = bus.src_out;
        if (reset && bus.valid_out && bus.ready_out) begin
            cons_total++;
            w_exp = 'x;
            if (bus.src_out == 1'b0) begin
                if (e0.size() != 0) w_exp = e0.pop_front();
                check("d0_order", bus.data_out, w_exp);
                exp_cnt0 = (exp_cnt0 + 1) % 256;
            end else begin
                if (e1.size() != 0) w_exp = e1.pop_front();
                check("d1_order", bus.data_out, w_exp);
                exp_cnt1 = (exp_cnt1 + 1) % 256;
            end
        end
        @(posedge clk);
        #1;
        if (pend0) begin
            check("d0_underflow", (q0.size() != 0), 1);
            if (q0.size() != 0) bus.data_out_D0 = q0.pop_front();
        end
        if (pend1) begin
            check("d1_underflow", (q1.size() != 0), 1);
            if (q1.size() != 0) bus.data_out_D1 = q1.pop_front();
        end
        bus.empty_fifo_D0 = (q0.size() == 0);
        bus.empty_fifo_D1 = (q1.size() == 0);
        @(negedge clk);
        if (reset) begin
            check("one_pop", bus.D0_pop & bus.D1_pop, 0);
            check("d0_back2back", bus.D0_pop & pend0, 0);
            check("d1_back2back", bus.D1_pop & pend1, 0);
            if (bus.D0_pop || bus.D1_pop) check("pop_in_run", bus.state_out, 1);
            pops_total += int'(bus.D0_pop) + int'(bus.D1_pop);
            check("inflight", (pops_total - cons_total <= DEPTH), 1);
            if (hold) begin
                check("hold_valid", bus.valid_out, 1);
                check("hold_data", bus.data_out, hold_data);
                check("hold_src", bus.src_out, hold_src);
            end
        end
`ifdef DEST_PKT_COUNT_EN
        check("count_d0", bus.count_D0, exp_cnt0);
        check("count_d1", bus.count_D1, exp_cnt1);
`else
        check("count_d0", bus.count_D0, 0);
        check("count_d1", bus.count_D1, 0);
`endif
        pend0 = bus.D0_pop;
        pend1 = bus.D1_pop;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        bus.active_in  = 1'b1;
        bus.error_in   = 1'b0;
        bus.ready_out  = 1'b0;
        exp_cnt0       = 0;
        exp_cnt1       = 0;
        hold           = 1'b0;
        repeat (2) cycle();
        q0.delete();
        q1.delete();
        e0.delete();
        e1.delete();
        pend0      = 1'b0;
        pend1      = 1'b0;
        pops_total = 0;
        cons_total = 0;
        reset      = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        bus.ready_out = 1'b1;
        bus.active_in = 1'b1;
        while ((e0.size() != 0 || e1.size() != 0 || bus.valid_out) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, (e0.size() == 0 && e1.size() == 0 && !bus.valid_out), 1);
    endtask

    initial begin
        int npops;
        int base;
        bus.active_in     = 1'b1;
        bus.error_in      = 1'b0;
        bus.ready_out     = 1'b1;
        bus.data_out_D0   = '0;
        bus.data_out_D1   = '0;
        bus.empty_fifo_D0 = 1'b1;
        bus.empty_fifo_D1 = 1'b1;

        // Reset held with D0 non-empty and active high
        reset = 1'b0;
        push0(6'h2A);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("rst_pop0_%0d", k), bus.D0_pop, 0);
            check($sformatf("rst_pop1_%0d", k), bus.D1_pop, 0);
            check($sformatf("rst_valid_%0d", k), bus.valid_out, 0);
            check($sformatf("rst_data_%0d", k), bus.data_out, 0);
            check($sformatf("rst_src_%0d", k), bus.src_out, 0);
            check($sformatf("rst_state_%0d", k), bus.state_out, 0);
        end
        reset = 1'b1;
        cycle();
        check("rst_release_state", bus.state_out, 1);
        drain("t1", 40);

        // Both FIFOs loaded: alternating pops, 2-cycle latency to the output
        do_reset();
        bus.ready_out = 1'b1;
        push0(6'h08); push0(6'h15);
        push1(6'h16); push1(6'h14);
        for (int k = 0; k < 7; k++) begin
            cycle();
            check($sformatf("t2_pop0_%0d", k + 1), bus.D0_pop, t2_p0[k]);
            check($sformatf("t2_pop1_%0d", k + 1), bus.D1_pop, t2_p1[k]);
            check($sformatf("t2_valid_%0d", k + 1), bus.valid_out, t2_v[k]);
            if (t2_v[k] != 0) begin
                check($sformatf("t2_data_%0d", k + 1), bus.data_out, t2_d[k]);
                check($sformatf("t2_src_%0d", k + 1), bus.src_out, t2_s[k]);
            end
        end
        drain("t2", 20);

        // Single FIFO: one pop every other cycle
        do_reset();
        bus.ready_out = 1'b1;
        push0(6'h31); push0(6'h0C); push0(6'h3F);
        for (int k = 0; k < 7; k++) begin
            cycle();
            check($sformatf("t3_pop0_%0d", k + 1), bus.D0_pop, t3_p0[k]);
            check($sformatf("t3_pop1_%0d", k + 1), bus.D1_pop, 0);
        end
        drain("t3", 20);

        // Backpressure: exactly OUT_DEPTH pops, head word held
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push0(DW'(6'h20 + i));
            push1(DW'(6'h10 + i));
        end
        npops = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            npops += int'(bus.D0_pop) + int'(bus.D1_pop);
        end
        check("t4_pop_count", npops, DEPTH);
        check("t4_valid_held", bus.valid_out, 1);
        check("t4_head_word", bus.data_out, 6'h20);
        check("t4_head_src", bus.src_out, 0);
        drain("t4", 60);
        check("t4_consumed", cons_total, 8);

        // Error with 3 words buffered: no more pops, drain, stay in ERROR
        do_reset();
        push0(6'h01); push0(6'h02); push1(6'h03);
        repeat (8) cycle();
        check("t5_buffered", bus.valid_out, 1);
        push0(6'h04); push1(6'h05);
        bus.error_in = 1'b1;
        cycle();
        bus.error_in = 1'b0;
        check("t5_state_err", bus.state_out, 3);
        npops = int'(bus.D0_pop) + int'(bus.D1_pop);
        base = cons_total;
        bus.ready_out = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            npops += int'(bus.D0_pop) + int'(bus.D1_pop);
            check($sformatf("t5_state_%0d", k), bus.state_out, 3);
        end
        check("t5_no_pops", npops, 0);
        check("t5_drained", cons_total - base, 3);
        check("t5_empty", bus.valid_out, 0);
        do_reset();
        cycle();
        check("t5_reset_state", bus.state_out, 1);

        // 257 words from D0: counter wraps once
        do_reset();
        bus.ready_out = 1'b1;
        for (int i = 0; i < 257; i++) push0(DW'(i));
        for (int n = 0; n < 1200 && cons_total < 257; n++) cycle();
        check("t6_consumed", cons_total, 257);
        cycle();
`ifdef DEST_PKT_COUNT_EN
        check("t6_count_d0", bus.count_D0, 1);
`else
        check("t6_count_d0", bus.count_D0, 0);
`endif
        check("t6_count_d1", bus.count_D1, 0);

        // Randomized traffic, sink stalls and active_in dips
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 6) push0(DW'($urandom));
            if ($urandom_range(0, 2) == 0 && q1.size() < 6) push1(DW'($urandom));
            bus.ready_out = ($urandom_range(0, 3) != 0);
            bus.active_in = ($urandom_range(0, 31) != 0);
            cycle();
        end
        drain("rand", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
